// File: rtl/alu_mdu_if.sv
// Multiply/divide handshake bundle between the execute stage and alu_mdu.
// The requester (pipeline/bench) uses the master modport; alu_mdu uses slave.
interface alu_mdu_if #(
    parameter int XLEN = 32
) ();
    logic [2:0]      MDUOpE;
    logic            MDUStartE;
    logic            FlushE;
    logic            MDUBusyE;
    logic            MDUValidE;
    logic [XLEN-1:0] MDUResultE;

    modport master (
        output MDUOpE, MDUStartE, FlushE,
        input  MDUBusyE, MDUValidE, MDUResultE
    );

    modport slave (
        input  MDUOpE, MDUStartE, FlushE,
        output MDUBusyE, MDUValidE, MDUResultE
    );
endinterface

// File: rtl/alu_mdu.sv
// Execute-stage ALU (single-cycle, combinational) plus an iterative
// multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle, with a divide fast path for divide-by-zero and signed overflow.
module alu_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] src_A,
    input  logic [XLEN-1:0] src_B,
    input  logic [3:0]      ALUControlE,
    output logic [XLEN-1:0] ALUResultE,
    output logic            ZERO,
    alu_mdu_if.slave        mdu
);
    localparam int LW = $clog2(XLEN);
    localparam int CW = LW + 1;
    localparam logic [CW-1:0]     CNT_LAST = CW'(XLEN);
    localparam logic [CW-1:0]     ONE_C    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [1:0]        r_op;
    logic [XLEN-1:0]   r_opa;      // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] r_acc;      // product, or {remainder, quotient/dividend}
    logic              r_neg_q;    // product / quotient needs negation
    logic              r_neg_r;    // remainder needs negation
    logic              r_fast;     // divide resolved without iterating
    logic [XLEN-1:0]   r_result;

    logic [XLEN-1:0]   w_alu_res;
    logic [LW-1:0]     w_shamt;
    logic              w_sa, w_sb, w_fast;
    logic [XLEN-1:0]   w_mag_a, w_mag_b, w_fast_res;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_t;
    logic [XLEN-1:0]   w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_mul_res, w_quot, w_rem, w_div_res;

    assign w_shamt = src_B[LW-1:0];

    // ALU opcode decode; unlisted opcodes give zero
    always_comb begin
        w_alu_res = {XLEN{1'b0}};
        case (ALUControlE)
            4'b0000: w_alu_res = src_A + src_B;
            4'b0001: w_alu_res = src_A - src_B;
            4'b0100: w_alu_res = src_A & src_B;
            4'b0101: w_alu_res = src_A | src_B;
            4'b0110: w_alu_res = src_A ^ src_B;
            4'b1000: w_alu_res = {{(XLEN-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
            4'b1001: w_alu_res = {{(XLEN-1){1'b0}}, (src_A < src_B)};
            4'b1110: w_alu_res = src_A << w_shamt;
            4'b1101: w_alu_res = src_A >> w_shamt;
            4'b1111: w_alu_res = $unsigned($signed(src_A) >>> w_shamt);
            default: w_alu_res = {XLEN{1'b0}};
        endcase
    end

    assign ALUResultE = w_alu_res;
    assign ZERO       = (w_alu_res == {XLEN{1'b0}});

    // Operand signedness, magnitudes and divide fast-path detection at start
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        if (mdu.MDUOpE[2]) begin
            w_sa = ~mdu.MDUOpE[0];
            w_sb = ~mdu.MDUOpE[0];
        end else begin
            w_sa = (mdu.MDUOpE[1:0] == 2'b01) || (mdu.MDUOpE[1:0] == 2'b10);
            w_sb = (mdu.MDUOpE[1:0] == 2'b01);
        end
        w_mag_a    = (w_sa && src_A[XLEN-1]) ? (~src_A + ONE_X) : src_A;
        w_mag_b    = (w_sb && src_B[XLEN-1]) ? (~src_B + ONE_X) : src_B;
        w_fast     = 1'b0;
        w_fast_res = {XLEN{1'b0}};
        if (src_B == {XLEN{1'b0}}) begin
            w_fast     = mdu.MDUOpE[2];
            w_fast_res = mdu.MDUOpE[1] ? src_A : {XLEN{1'b1}};
        end else if (w_sa && (src_A == MOST_NEG) && (src_B == {XLEN{1'b1}})) begin
            w_fast     = mdu.MDUOpE[2];
            w_fast_res = mdu.MDUOpE[1] ? {XLEN{1'b0}} : src_A;
        end else begin
            w_fast     = 1'b0;
            w_fast_res = {XLEN{1'b0}};
        end
    end

    // One iteration step of each algorithm and the final sign-corrected results
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opa} : {(XLEN+1){1'b0}});
        w_div_t    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_div_ge   = (w_div_t >= {1'b0, r_opa});
        w_div_diff = w_div_t[XLEN-1:0] - r_opa;
        w_prod_fix = r_neg_q ? (~r_acc + ONE_2X) : r_acc;
        w_mul_res  = (r_op == 2'b00) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];
        w_quot     = r_neg_q ? (~r_acc[XLEN-1:0] + ONE_X) : r_acc[XLEN-1:0];
        w_rem      = r_neg_r ? (~r_acc[2*XLEN-1:XLEN] + ONE_X) : r_acc[2*XLEN-1:XLEN];
        w_div_res  = r_op[1] ? w_rem : w_quot;
    end

    // FSM next-state: flush always wins, start only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mdu.FlushE)          w_state_nxt = S_IDLE;
                else if (mdu.MDUStartE)  w_state_nxt = mdu.MDUOpE[2] ? S_DIV : S_MUL;
                else                     w_state_nxt = S_IDLE;
            end
            S_MUL: begin
                if (mdu.FlushE)              w_state_nxt = S_IDLE;
                else if (r_cnt == CNT_LAST)  w_state_nxt = S_DONE;
                else                         w_state_nxt = S_MUL;
            end
            S_DIV: begin
                if (mdu.FlushE)                      w_state_nxt = S_IDLE;
                else if (r_fast || (r_cnt == CNT_LAST)) w_state_nxt = S_DONE;
                else                                 w_state_nxt = S_DIV;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= {CW{1'b0}};
            r_op     <= 2'b00;
            r_opa    <= {XLEN{1'b0}};
            r_acc    <= {(2*XLEN){1'b0}};
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_fast   <= 1'b0;
            r_result <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mdu.MDUStartE && !mdu.FlushE) begin
                        r_op    <= mdu.MDUOpE[1:0];
                        r_cnt   <= {CW{1'b0}};
                        r_neg_q <= (w_sa & src_A[XLEN-1]) ^ (w_sb & src_B[XLEN-1]);
                        r_neg_r <= w_sa & src_A[XLEN-1];
                        r_fast  <= w_fast;
                        if (mdu.MDUOpE[2]) begin
                            r_opa <= w_mag_b;
                            r_acc <= {{XLEN{1'b0}}, (w_fast ? w_fast_res : w_mag_a)};
                        end else begin
                            r_opa <= w_mag_a;
                            r_acc <= {{XLEN{1'b0}}, w_mag_b};
                        end
                    end
                end
                S_MUL: begin
                    if (!mdu.FlushE) begin
                        if (r_cnt == CNT_LAST) begin
                            r_result <= w_mul_res;
                        end else begin
                            r_acc <= {w_mul_sum, r_acc[XLEN-1:1]};
                            r_cnt <= r_cnt + ONE_C;
                        end
                    end
                end
                S_DIV: begin
                    if (!mdu.FlushE) begin
                        if (r_fast) begin
                            r_result <= r_acc[XLEN-1:0];
                        end else if (r_cnt == CNT_LAST) begin
                            r_result <= w_div_res;
                        end else begin
                            r_acc <= {(w_div_ge ? w_div_diff : w_div_t[XLEN-1:0]),
                                      r_acc[XLEN-2:0], w_div_ge};
                            r_cnt <= r_cnt + ONE_C;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign mdu.MDUBusyE   = (r_state != S_IDLE);
    assign mdu.MDUValidE  = (r_state == S_DONE);
    assign mdu.MDUResultE = r_result;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: ALU vectors, MDU scoreboard with latency
// tracking, flush / ignored-start / async-reset cases and an XLEN=8 instance.
module tb_alu_mdu;
    localparam int XL = 32;

    logic        clk;
    logic        rst_n;
    logic [31:0] src_A, src_B, ALUResultE;
    logic [3:0]  ALUControlE;
    logic        ZERO;
    logic [7:0]  src_A8, src_B8, ALUResultE8;
    logic [3:0]  ALUControlE8;
    logic        ZERO8;

    alu_mdu_if #(.XLEN(32)) mdu_if ();
    alu_mdu_if #(.XLEN(8))  mdu8_if ();

    alu_mdu #(.XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .src_A(src_A), .src_B(src_B),
        .ALUControlE(ALUControlE), .ALUResultE(ALUResultE), .ZERO(ZERO), .mdu(mdu_if)
    );

    alu_mdu #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .src_A(src_A8), .src_B(src_B8),
        .ALUControlE(ALUControlE8), .ALUResultE(ALUResultE8), .ZERO(ZERO8), .mdu(mdu8_if)
    );

    typedef struct {
        logic [31:0] res;
        int          due;
    } exp_t;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } mdu_vec_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          valid_cnt = 0;
    logic [31:0] last_res = 32'h0;
    alu_vec_t    alu_tab[12];
    mdu_vec_t    mdu_tab[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cycle counter: value after edge n is n
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // independent reference for all eight MDU ops at 32 bits
    function automatic logic [31:0] mdu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        int          sa, sb;
        logic        ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'h0;
        case (op)
            3'd0: begin p = {32'h0, a} * {32'h0, b};               return p[31:0];  end
            3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b};   return p[63:32]; end
            3'd2: begin p = {{32{a[31]}}, a} * {32'h0, b};         return p[63:32]; end
            3'd3: begin p = {32'h0, a} * {32'h0, b};               return p[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf)        return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf)        return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 32'h0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 32'h0) return 1'b1;
        return !op[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // scoreboard: every valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && mdu_if.MDUValidE) begin
            valid_cnt++;
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("mdu_result", mdu_if.MDUResultE, e.res);
                check("mdu_latency", cyc, e.due);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (sb_q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (sb_q.size() != 0) begin
            check("drain_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        exp_t e;
        mdu_if.MDUOpE    = op;
        src_A            = a;
        src_B            = b;
        mdu_if.MDUStartE = 1'b1;
        @(posedge clk);
        #1;
        mdu_if.MDUStartE = 1'b0;
        e.res = exp;
        e.due = cyc + (is_fast(op, a, b) ? 1 : XL + 1);
        sb_q.push_back(e);
        last_res = exp;
        check("busy_after_start", mdu_if.MDUBusyE, 1);
        src_A         = $urandom;
        src_B         = $urandom;
        mdu_if.MDUOpE = 3'($urandom_range(0, 7));
        wait_drain();
        check("idle_after_done", mdu_if.MDUBusyE, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k, lat, v0;
        bit          found;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        rst_n = 1'b0;
        src_A = 32'h0; src_B = 32'h0; ALUControlE = 4'b0000;
        src_A8 = 8'h0; src_B8 = 8'h0; ALUControlE8 = 4'b0000;
        mdu_if.MDUOpE = 3'd0;  mdu_if.MDUStartE = 1'b0;  mdu_if.FlushE = 1'b0;
        mdu8_if.MDUOpE = 3'd0; mdu8_if.MDUStartE = 1'b0; mdu8_if.FlushE = 1'b0;
        #2;
        check("rst_busy",   mdu_if.MDUBusyE, 0);
        check("rst_valid",  mdu_if.MDUValidE, 0);
        check("rst_result", mdu_if.MDUResultE, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        alu_tab = '{
            '{4'b1111, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
            '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000},
            '{4'b0011, 32'h1234_5678, 32'h0000_0009, 32'h0000_0000},
            '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
            '{4'b0101, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0},
            '{4'b0110, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00},
            '{4'b1000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
            '{4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
            '{4'b1110, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008},
            '{4'b1101, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
            '{4'b1111, 32'h8000_0000, 32'h0000_003F, 32'hFFFF_FFFF}
        };
        foreach (alu_tab[i]) begin
            ALUControlE = alu_tab[i].ctl;
            src_A       = alu_tab[i].a;
            src_B       = alu_tab[i].b;
            #1;
            check($sformatf("alu_%0d", i), ALUResultE, alu_tab[i].exp);
            check($sformatf("zero_%0d", i), ZERO, (alu_tab[i].exp == 32'h0));
        end
        ALUControlE8 = 4'b1111; src_A8 = 8'h80; src_B8 = 8'h04;
        #1;
        check("alu8_sra", ALUResultE8, 8'hF8);

        @(posedge clk);
        #1;
        mdu_tab = '{
            '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
            '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
            '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
            '{3'd5, 32'd100,       32'd7,         32'd14},
            '{3'd7, 32'd100,       32'd7,         32'd2},
            '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF},
            '{3'd6, 32'd5,         32'd0,         32'd5},
            '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
        };
        foreach (mdu_tab[i]) issue(mdu_tab[i].op, mdu_tab[i].a, mdu_tab[i].b, mdu_tab[i].exp);

        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(rop, ra, rb, mdu_ref(rop, ra, rb));
        end

        // flush at iteration 10: no pulse, previous result kept
        v0 = valid_cnt;
        mdu_if.MDUOpE = 3'd3; src_A = 32'h1234_5678; src_B = 32'h9ABC_DEF0;
        mdu_if.MDUStartE = 1'b1;
        @(posedge clk); #1;
        mdu_if.MDUStartE = 1'b0;
        repeat (9) @(posedge clk);
        #1 mdu_if.FlushE = 1'b1;
        @(posedge clk); #1;
        mdu_if.FlushE = 1'b0;
        check("flush_idle", mdu_if.MDUBusyE, 0);
        check("flush_keep", mdu_if.MDUResultE, last_res);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_valid", valid_cnt - v0, 0);

        // flush together with start in IDLE: start dropped
        mdu_if.MDUOpE = 3'd0; mdu_if.MDUStartE = 1'b1; mdu_if.FlushE = 1'b1;
        @(posedge clk); #1;
        mdu_if.MDUStartE = 1'b0; mdu_if.FlushE = 1'b0;
        check("flush_start_idle", mdu_if.MDUBusyE, 0);

        // start while busy is ignored: only one result
        v0 = valid_cnt;
        mdu_if.MDUOpE = 3'd0; src_A = 32'd3; src_B = 32'd5;
        mdu_if.MDUStartE = 1'b1;
        @(posedge clk); #1;
        begin
            exp_t e;
            e.res = 32'd15;
            e.due = cyc + XL + 1;
            sb_q.push_back(e);
        end
        last_res = 32'd15;
        mdu_if.MDUOpE = 3'd4; src_A = 32'd77; src_B = 32'd3;
        repeat (3) @(posedge clk);
        #1 mdu_if.MDUStartE = 1'b0;
        wait_drain();
        repeat (40) @(posedge clk);
        #1;
        check("busy_start_ignored", valid_cnt - v0, 1);

        // XLEN=8 mulhu and latency
        mdu8_if.MDUOpE = 3'd3; src_A8 = 8'hFF; src_B8 = 8'hFF;
        mdu8_if.MDUStartE = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        mdu8_if.MDUStartE = 1'b0;
        found = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mdu8_if.MDUValidE) begin
                lat = cyc - k;
                found = 1'b1;
                break;
            end
        end
        check("x8_valid_seen", found, 1);
        check("x8_latency", lat, 9);
        check("x8_mulhu", mdu8_if.MDUResultE, 8'hFE);
        @(posedge clk); #1;

        // async reset in the middle of a divide
        mdu_if.MDUOpE = 3'd5; src_A = 32'd1000; src_B = 32'd3;
        mdu_if.MDUStartE = 1'b1;
        @(posedge clk); #1;
        mdu_if.MDUStartE = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy",     mdu_if.MDUBusyE, 0);
        check("arst_valid",    mdu_if.MDUValidE, 0);
        check("arst_result",   mdu_if.MDUResultE, 0);
        check("arst_result8",  mdu8_if.MDUResultE, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'd5, 32'd1000, 32'd3, 32'd333);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
